wqe_dispatcher: RTL
===================

// Module: wqe_dispatcher
// PURPOSE
//  Producer side of the TX WQE scheduling path. Accepts fetched WQEs and routes them by type.
//  - Latency-sensitive (LS) WQEs go into the LS WQE FIFO.
//  - Bandwidth-sensitive WQEs become pending WQEs (pWQEs) in their own station-buffer slot, via write port 0.
//  Owns the per-slot occupancy vector that the group scheduler arbitrates over.
//  Frees a slot when the transport reports that the slot's pWQE has completed.
// PARAMETERS
//  WQE_WIDTH            512  width of one WQE
//  PWQE_SLOT_NUM        4    number of station-buffer slots, one per bandwidth-sensitive SQ
//  PWQE_BUF_ADDR_WIDTH  2    slot address width, log2(PWQE_SLOT_NUM)
//  PWQE_BUF_WIDTH       512  station-buffer word width, equal to WQE_WIDTH
//  CNT_WIDTH            16   width of the statistics counters
// PORTS
//  clk              in   1                    single clock
//  rst_n            in   1                    asynchronous active-low reset
//  i_wqe_val        in   1                    input WQE valid
//  o_wqe_rdy        out  1                    input WQE ready; transfer when val&rdy
//  i_wqe_type       in   1                    0 = LS, 1 = bandwidth-sensitive
//  i_wqe_slot       in   PWQE_BUF_ADDR_WIDTH  target slot for a bandwidth-sensitive WQE; ignored for LS
//  i_wqe            in   WQE_WIDTH            WQE payload
//  i_ls_wqe_full    in   1                    LS FIFO full
//  o_ls_wqe_wen     out  1                    LS FIFO write strobe
//  o_ls_wqe_wdata   out  WQE_WIDTH            LS FIFO write data
//  o_wen_0          out  1                    station buffer port-0 write enable
//  o_addr_0         out  PWQE_BUF_ADDR_WIDTH  station buffer port-0 address
//  o_din_0          out  PWQE_BUF_WIDTH       station buffer port-0 write data
//  o_slot_status    out  PWQE_SLOT_NUM        bit n = 1: slot n holds a live pWQE
//  i_slot_clr       in   1                    pulse: pWQE in i_slot_clr_addr has completed
//  i_slot_clr_addr  in   PWQE_BUF_ADDR_WIDTH  slot to free
//  o_ls_cnt         out  CNT_WIDTH            LS WQEs dispatched
//  o_bs_cnt         out  CNT_WIDTH            bandwidth-sensitive WQEs dispatched
//  o_err            out  1                    sticky: clear of an already-free slot
// BEHAVIOUR
//  Reset: every output reg = 0, hold register empty, o_slot_status = 0, counters = 0, o_err = 0.
//  One-entry hold register (hold_val, hold_type, hold_slot, hold_wqe). A WQE is captured on val&rdy.
//  disp_go = hold_val & (hold_type ? ~o_slot_status[hold_slot] : ~i_ls_wqe_full).
//   - Uses registered state only; never depends on i_wqe*.
//  o_wqe_rdy = ~hold_val | disp_go (combinational).
//   - Back-to-back transfers give one WQE per cycle while the destination is free.
//  On the disp_go edge:
//   - LS type: o_ls_wqe_wen = 1, o_ls_wqe_wdata = hold_wqe, o_ls_cnt += 1.
//   - Bandwidth-sensitive type: o_wen_0 = 1, o_addr_0 = hold_slot, o_din_0 = hold_wqe,
//     o_slot_status[hold_slot] set to 1 on the same edge, o_bs_cnt += 1.
//   - Hold register is reloaded if val&rdy, otherwise emptied.
//  Write strobes are single-cycle pulses, 0 otherwise.
//  o_addr_0 and o_din_0 keep their last value; o_ls_wqe_wdata keeps its last value.
//  Latency: accept edge to write strobe = 1 cycle when the destination is free.
//  Slot status is set on the same edge as o_wen_0; RAM commits on the next edge.
//   - The scheduler's earliest read of that slot is 2 edges later, so there is no read-before-write.
//  Blocked destination (LS full or target slot busy): WQE waits in hold, o_wqe_rdy = 0.
//   - Head-of-line blocking is intended; no reordering.
//  Clear: an i_slot_clr edge sets o_slot_status[i_slot_clr_addr] to 0.
//   - If that bit was already 0, set o_err (sticky until reset).
//  Same-edge dispatch-set and clear on the same slot:
//   - Cannot be legal, because the set requires the bit to be 0.
//   - The clear then hits a free slot: set wins and o_err is raised.
//  Same-edge set and clear on different slots: both take effect.
//  Counters wrap modulo 2^CNT_WIDTH.
//  Reset mid-operation discards hold contents and clears all slots immediately (asynchronous).
// TESTING
//  1. LS WQE 0xA5.., full=0 -> o_ls_wqe_wen 1 cycle after accept, wdata=0xA5.., o_ls_cnt=1.
//  2. BS WQE slot 2 -> o_wen_0=1, o_addr_0=2, o_slot_status=4'b0100 same edge; second WQE to slot 2 stalls with rdy=0.
//  3. While test-2 WQE stalls: i_slot_clr addr 2 -> bit clears, stalled WQE written next edge, status back to 4'b0100.
//  4. Back-to-back 4 BS WQEs to slots 0..3 -> 4 consecutive o_wen_0 pulses, status=4'hF, o_bs_cnt=4.
//  5. i_ls_wqe_full=1 for 5 cycles with LS WQE held -> no wen, rdy=0; release -> wen next edge.
//  6. Clear of free slot 1 -> o_err=1 and stays 1; then assert rst_n=0 mid-stall -> all outputs/status 0.

Source files
------------

// File: rtl/wqe_dispatcher.sv
// TX WQE dispatcher. It routes fetched WQEs either to the LS FIFO or to their station-buffer slot.
// It also owns the slot occupancy vector that the group scheduler arbitrates over.
module wqe_dispatcher #(
  parameter int WQE_WIDTH           = 512,
  parameter int PWQE_SLOT_NUM       = 4,
  parameter int PWQE_BUF_ADDR_WIDTH = 2,
  parameter int PWQE_BUF_WIDTH      = 512,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_wqe_val,
  output logic                           o_wqe_rdy,
  input  logic                           i_wqe_type,
  input  logic [PWQE_BUF_ADDR_WIDTH-1:0] i_wqe_slot,
  input  logic [WQE_WIDTH-1:0]           i_wqe,
  input  logic                           i_ls_wqe_full,
  output logic                           o_ls_wqe_wen,
  output logic [WQE_WIDTH-1:0]           o_ls_wqe_wdata,
  output logic                           o_wen_0,
  output logic [PWQE_BUF_ADDR_WIDTH-1:0] o_addr_0,
  output logic [PWQE_BUF_WIDTH-1:0]      o_din_0,
  output logic [PWQE_SLOT_NUM-1:0]       o_slot_status,
  input  logic                           i_slot_clr,
  input  logic [PWQE_BUF_ADDR_WIDTH-1:0] i_slot_clr_addr,
  output logic [CNT_WIDTH-1:0]           o_ls_cnt,
  output logic [CNT_WIDTH-1:0]           o_bs_cnt,
  output logic                           o_err
);

  logic                           hold_val;
  logic                           hold_type;
  logic [PWQE_BUF_ADDR_WIDTH-1:0] hold_slot;
  logic [WQE_WIDTH-1:0]           hold_wqe;
  logic                           disp_go;
  logic                           accept;
  logic [PWQE_SLOT_NUM-1:0]       status_nxt;
  logic                           clr_err;

  // Dispatch decision looks only at registered state, so the input handshake never loops back into it
  assign disp_go   = hold_val & (hold_type ? ~o_slot_status[hold_slot] : ~i_ls_wqe_full);
  assign o_wqe_rdy = ~hold_val | disp_go;
  assign accept    = i_wqe_val & o_wqe_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_val  <= 1'b0;
      hold_type <= 1'b0;
      hold_slot <= '0;
      hold_wqe  <= '0;
    end else begin
      hold_val <= accept | (hold_val & ~disp_go);
      if (accept) begin
        hold_type <= i_wqe_type;
        hold_slot <= i_wqe_slot;
        hold_wqe  <= i_wqe;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ls_wqe_wen   <= 1'b0;
      o_ls_wqe_wdata <= '0;
      o_wen_0        <= 1'b0;
      o_addr_0       <= '0;
      o_din_0        <= '0;
      o_ls_cnt       <= '0;
      o_bs_cnt       <= '0;
    end else begin
      o_ls_wqe_wen <= disp_go & ~hold_type;
      o_wen_0      <= disp_go & hold_type;
      if (disp_go && !hold_type) begin
        o_ls_wqe_wdata <= hold_wqe;
        o_ls_cnt       <= o_ls_cnt + CNT_WIDTH'(1);
      end
      if (disp_go && hold_type) begin
        o_addr_0 <= hold_slot;
        o_din_0  <= PWQE_BUF_WIDTH'(hold_wqe);
        o_bs_cnt <= o_bs_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // A set is applied after the clear, so a same-slot collision leaves the slot occupied
  always_comb begin
    status_nxt = o_slot_status;
    clr_err    = 1'b0;
    if (i_slot_clr) begin
      clr_err                     = ~o_slot_status[i_slot_clr_addr];
      status_nxt[i_slot_clr_addr] = 1'b0;
    end
    if (disp_go && hold_type) begin
      status_nxt[hold_slot] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_slot_status <= '0;
      o_err         <= 1'b0;
    end else begin
      o_slot_status <= status_nxt;
      if (clr_err) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule
